uart16550_tx_sched: RTL and testbench



---
 rtl/uart16550_pkg.sv | 17 +
 rtl/uart16550_tx_sched_if.sv | 31 +++
 rtl/uart16550_sync2.sv | 28 ++
 rtl/uart16550_tx_sched.sv | 136 +++++++++++++
 tb/tb_uart16550_tx_sched.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart16550_pkg.sv
// rtl/uart16550_pkg.sv - shared UART16550 types and constants
// Contents:
//   stage_state_e  staging register state (ST_EMPTY / ST_FC / ST_DATA)
//   XON_DEFAULT    default XON flow-control character
//   XOFF_DEFAULT   default XOFF flow-control character
package uart16550_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FC    = 2'd1,
        ST_DATA  = 2'd2
    } stage_state_e;

    localparam logic [7:0] XON_DEFAULT  = 8'h11;
    localparam logic [7:0] XOFF_DEFAULT = 8'h13;

endpackage

// File: rtl/uart16550_tx_sched_if.sv
// rtl/uart16550_tx_sched_if.sv - TX FIFO and transmitter handshake bundle
// Signals:
//   fifo_empty_i  TX FIFO empty
//   fifo_q_i      TX FIFO head (show-ahead)
//   fifo_pop_o    pop TX FIFO head
//   tx_pop_i      transmitter takes tx_d_o this cycle
//   tx_d_o        staged character
//   tx_thre_o     transmitter holding register empty
//   sr_empty_i    transmitter shift register empty
// Modports: master = scheduler side, slave = FIFO/transmitter side.
interface uart16550_tx_sched_if;

    logic       fifo_empty_i;
    logic [7:0] fifo_q_i;
    logic       fifo_pop_o;
    logic       tx_pop_i;
    logic [7:0] tx_d_o;
    logic       tx_thre_o;
    logic       sr_empty_i;

    modport master (
        input  fifo_empty_i, fifo_q_i, tx_pop_i, sr_empty_i,
        output fifo_pop_o, tx_d_o, tx_thre_o
    );

    modport slave (
        output fifo_empty_i, fifo_q_i, tx_pop_i, sr_empty_i,
        input  fifo_pop_o, tx_d_o, tx_thre_o
    );

endinterface

// File: rtl/uart16550_sync2.sv
// rtl/uart16550_sync2.sv - generic 2-flop synchronizer for modem inputs
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, both flops load RESET_VAL
//   d_i     asynchronous input
//   q_o     synchronized output
module uart16550_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            q_o    <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/uart16550_tx_sched.sv
// rtl/uart16550_tx_sched.sv - transmit scheduler: FIFO vs XON/XOFF arbitration
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   afe_i                auto flow control enable (CTS gating of FIFO data)
//   swfc_en_i            software flow control enable
//   cts_ni               modem CTS, active low, asynchronous
//   xon_req_i/xoff_req_i single-cycle flow-control requests
//   tx_if                FIFO / transmitter handshake (master modport)
//   temt_o               LSR.TEMT
//   xoff_sent_o          last flow-control character sent was XOFF
module uart16550_tx_sched
    import uart16550_pkg::*;
#(
    parameter logic [7:0] XON_CHAR  = XON_DEFAULT,
    parameter logic [7:0] XOFF_CHAR = XOFF_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        afe_i,
    input  logic                        swfc_en_i,
    input  logic                        cts_ni,
    input  logic                        xon_req_i,
    input  logic                        xoff_req_i,
    uart16550_tx_sched_if.master        tx_if,
    output logic                        temt_o,
    output logic                        xoff_sent_o
);

    stage_state_e state_q, state_d;
    logic [7:0]   data_q, data_d;
    logic         fc_xoff_q, fc_xoff_d;     // staged FC character is XOFF
    logic         xon_pend_q, xon_pend_d;
    logic         xoff_pend_q, xoff_pend_d;
    logic         xoff_sent_q, xoff_sent_d;
    logic         cts_sync;
    logic         cts_ok;
    logic         load_fifo;

    uart16550_sync2 #(.RESET_VAL(1'b1)) u_cts_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cts_ni),
        .q_o    (cts_sync)
    );

    assign cts_ok = !afe_i || !cts_sync;

    // FIFO data is only taken when no flow-control character is waiting.
    assign load_fifo = (state_q == ST_EMPTY) && !xoff_pend_q && !xon_pend_q &&
                       !tx_if.fifo_empty_i && cts_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            data_q      <= 8'h00;
            fc_xoff_q   <= 1'b0;
            xon_pend_q  <= 1'b0;
            xoff_pend_q <= 1'b0;
            xoff_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            fc_xoff_q   <= fc_xoff_d;
            xon_pend_q  <= xon_pend_d;
            xoff_pend_q <= xoff_pend_d;
            xoff_sent_q <= xoff_sent_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        fc_xoff_d   = fc_xoff_q;
        xon_pend_d  = xon_pend_q;
        xoff_pend_d = xoff_pend_q;
        xoff_sent_d = xoff_sent_q;

        case (state_q)
            ST_EMPTY: begin
                if (xoff_pend_q) begin
                    state_d     = ST_FC;
                    data_d      = XOFF_CHAR;
                    fc_xoff_d   = 1'b1;
                    xoff_pend_d = 1'b0;
                end else if (xon_pend_q) begin
                    state_d    = ST_FC;
                    data_d     = XON_CHAR;
                    fc_xoff_d  = 1'b0;
                    xon_pend_d = 1'b0;
                end else if (load_fifo) begin
                    state_d = ST_DATA;
                    data_d  = tx_if.fifo_q_i;
                end
            end
            ST_FC: begin
                if (tx_if.tx_pop_i) begin
                    state_d     = ST_EMPTY;
                    xoff_sent_d = fc_xoff_q;
                end
            end
            ST_DATA: begin
                if (tx_if.tx_pop_i) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // New requests are applied after the load so a request arriving in
        // the load cycle is kept pending rather than lost.
        if (!swfc_en_i) begin
            xon_pend_d  = 1'b0;
            xoff_pend_d = 1'b0;
        end else if (xoff_req_i) begin
            xoff_pend_d = 1'b1;
            xon_pend_d  = 1'b0;
        end else if (xon_req_i) begin
            xon_pend_d  = 1'b1;
            xoff_pend_d = 1'b0;
        end
    end

    always_comb begin
        tx_if.fifo_pop_o = load_fifo;
        tx_if.tx_d_o     = data_q;
        xoff_sent_o      = xoff_sent_q;
        temt_o           = (state_q == ST_EMPTY) && tx_if.fifo_empty_i &&
                           tx_if.sr_empty_i && !xon_pend_q && !xoff_pend_q;
        case (state_q)
            ST_FC:   tx_if.tx_thre_o = 1'b0;
            ST_DATA: tx_if.tx_thre_o = !cts_ok;   // held byte waits for CTS
            default: tx_if.tx_thre_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart16550_tx_sched.sv
// tb/tb_uart16550_tx_sched.sv - directed self-checking bench for uart16550_tx_sched
module tb_uart16550_tx_sched;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic afe_i, swfc_en_i, cts_ni, xon_req_i, xoff_req_i;
    logic temt_o, xoff_sent_o;
    int   n_checks = 0;
    int   n_errors = 0;

    uart16550_tx_sched_if tx_if ();

    uart16550_tx_sched dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .afe_i       (afe_i),
        .swfc_en_i   (swfc_en_i),
        .cts_ni      (cts_ni),
        .xon_req_i   (xon_req_i),
        .xoff_req_i  (xoff_req_i),
        .tx_if       (tx_if),
        .temt_o      (temt_o),
        .xoff_sent_o (xoff_sent_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni             = 1'b0;
        afe_i              = 1'b0;
        swfc_en_i          = 1'b1;
        cts_ni             = 1'b0;
        xon_req_i          = 1'b0;
        xoff_req_i         = 1'b0;
        tx_if.fifo_empty_i = 1'b1;
        tx_if.fifo_q_i     = 8'h00;
        tx_if.tx_pop_i     = 1'b0;
        tx_if.sr_empty_i   = 1'b1;
        repeat (3) tick();
        check("rst_pop",  tx_if.fifo_pop_o, 1'b0);
        check("rst_d",    tx_if.tx_d_o,     8'h00);
        check("rst_thre", tx_if.tx_thre_o,  1'b1);
        check("rst_temt", temt_o,           1'b1);
        check("rst_xsent", xoff_sent_o,     1'b0);
        rst_ni = 1'b1;
        tick();

        // two FIFO bytes, no flow control
        tx_if.fifo_empty_i = 1'b0; tx_if.fifo_q_i = 8'hA5; #1;
        check("t1_pop_a", tx_if.fifo_pop_o, 1'b1);
        check("t1_thre_e", tx_if.tx_thre_o, 1'b1);
        tick();
        check("t1_d_a",   tx_if.tx_d_o,    8'hA5);
        check("t1_thre_a", tx_if.tx_thre_o, 1'b0);
        tx_if.fifo_q_i = 8'h3C; #1;
        check("t1_nopop", tx_if.fifo_pop_o, 1'b0);
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t1_thre_bub", tx_if.tx_thre_o, 1'b1);
        check("t1_pop_b", tx_if.fifo_pop_o, 1'b1);
        tick();
        check("t1_d_b",   tx_if.tx_d_o,    8'h3C);
        check("t1_thre_b", tx_if.tx_thre_o, 1'b0);
        tx_if.fifo_empty_i = 1'b1;
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t1_thre_end", tx_if.tx_thre_o, 1'b1);
        check("t1_pop_end", tx_if.fifo_pop_o, 1'b0);
        check("t1_temt",  temt_o, 1'b1);

        // XOFF requested while a data byte is staged
        tx_if.fifo_empty_i = 1'b0; tx_if.fifo_q_i = 8'h55; #1;
        check("t2_pop", tx_if.fifo_pop_o, 1'b1);
        tick();
        tx_if.fifo_empty_i = 1'b1;
        check("t2_d55", tx_if.tx_d_o, 8'h55);
        xoff_req_i = 1'b1; tick(); xoff_req_i = 1'b0;
        check("t2_d55_hold", tx_if.tx_d_o, 8'h55);
        check("t2_thre55", tx_if.tx_thre_o, 1'b0);
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t2_thre_bub", tx_if.tx_thre_o, 1'b1);
        check("t2_temt_pend", temt_o, 1'b0);
        tick();
        check("t2_d13", tx_if.tx_d_o, 8'h13);
        check("t2_thre13", tx_if.tx_thre_o, 1'b0);
        check("t2_xsent_pre", xoff_sent_o, 1'b0);
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t2_xsent", xoff_sent_o, 1'b1);
        check("t2_thre_end", tx_if.tx_thre_o, 1'b1);
        check("t2_temt", temt_o, 1'b1);

        // simultaneous XON and XOFF: only XOFF survives
        xon_req_i = 1'b1; xoff_req_i = 1'b1; tick();
        xon_req_i = 1'b0; xoff_req_i = 1'b0; #1;
        check("t3_temt_pend", temt_o, 1'b0);
        tick();
        check("t3_d13", tx_if.tx_d_o, 8'h13);
        check("t3_thre", tx_if.tx_thre_o, 1'b0);
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t3_temt", temt_o, 1'b1);
        tick();
        check("t3_no_xon", tx_if.tx_thre_o, 1'b1);
        check("t3_d_hold", tx_if.tx_d_o, 8'h13);

        // TEMT follows the shift register and pending XON
        tx_if.sr_empty_i = 1'b0; #1;
        check("t5_temt_sr0", temt_o, 1'b0);
        tx_if.sr_empty_i = 1'b1; #1;
        check("t5_temt_sr1", temt_o, 1'b1);
        tx_if.fifo_empty_i = 1'b0; tx_if.fifo_q_i = 8'hC3; #1;
        tick();
        tx_if.fifo_empty_i = 1'b1;
        check("t5_dc3", tx_if.tx_d_o, 8'hC3);
        xon_req_i = 1'b1; tick(); xon_req_i = 1'b0;
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t5_temt_xon", temt_o, 1'b0);
        tick();
        check("t5_d11", tx_if.tx_d_o, 8'h11);
        check("t5_thre11", tx_if.tx_thre_o, 1'b0);
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t5_xsent_clr", xoff_sent_o, 1'b0);
        check("t5_temt_end", temt_o, 1'b1);
        swfc_en_i = 1'b0;
        xoff_req_i = 1'b1; tick(); xoff_req_i = 1'b0; #1;
        check("t5_swfc_off_temt", temt_o, 1'b1);
        tick();
        check("t5_swfc_off_thre", tx_if.tx_thre_o, 1'b1);
        swfc_en_i = 1'b1;

        // auto-CTS gating of a held byte, then of an unloaded FIFO head
        cts_ni = 1'b1;
        tx_if.fifo_empty_i = 1'b0; tx_if.fifo_q_i = 8'h77; #1;
        check("t4_pop", tx_if.fifo_pop_o, 1'b1);
        tick();
        tx_if.fifo_empty_i = 1'b1;
        check("t4_d77", tx_if.tx_d_o, 8'h77);
        check("t4_thre_noafe", tx_if.tx_thre_o, 1'b0);
        tick(); tick();
        afe_i = 1'b1; #1;
        check("t4_thre_gated", tx_if.tx_thre_o, 1'b1);
        xoff_req_i = 1'b1; tick(); xoff_req_i = 1'b0;
        tick(); tick();
        check("t4_thre_held", tx_if.tx_thre_o, 1'b1);
        check("t4_d_held", tx_if.tx_d_o, 8'h77);
        cts_ni = 1'b0;
        tick();
        check("t4_thre_sync1", tx_if.tx_thre_o, 1'b1);
        tick();
        check("t4_thre_sync2", tx_if.tx_thre_o, 1'b0);
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t4_thre_bub", tx_if.tx_thre_o, 1'b1);
        tick();
        check("t4_d13", tx_if.tx_d_o, 8'h13);
        check("t4_thre13", tx_if.tx_thre_o, 1'b0);
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t4_xsent", xoff_sent_o, 1'b1);
        cts_ni = 1'b1; tick(); tick();
        tx_if.fifo_empty_i = 1'b0; tx_if.fifo_q_i = 8'h99; #1;
        check("t4_gate_pop", tx_if.fifo_pop_o, 1'b0);
        tick();
        check("t4_gate_thre", tx_if.tx_thre_o, 1'b1);
        cts_ni = 1'b0;
        tick();
        check("t4_rel_pop1", tx_if.fifo_pop_o, 1'b0);
        tick();
        check("t4_rel_pop2", tx_if.fifo_pop_o, 1'b1);
        tick();
        tx_if.fifo_empty_i = 1'b1;
        check("t4_d99", tx_if.tx_d_o, 8'h99);
        check("t4_thre99", tx_if.tx_thre_o, 1'b0);
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0;
        afe_i = 1'b0;

        // reset with XOFF staged and XON pending
        xoff_req_i = 1'b1; tick(); xoff_req_i = 1'b0;
        tick();
        check("t6_d13", tx_if.tx_d_o, 8'h13);
        xon_req_i = 1'b1; tick(); xon_req_i = 1'b0;
        #2 rst_ni = 1'b0; #1;
        check("t6_rst_thre", tx_if.tx_thre_o, 1'b1);
        check("t6_rst_d", tx_if.tx_d_o, 8'h00);
        check("t6_rst_temt", temt_o, 1'b1);
        check("t6_rst_xsent", xoff_sent_o, 1'b0);
        check("t6_rst_pop", tx_if.fifo_pop_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_idle_thre", tx_if.tx_thre_o, 1'b1);
        end
        tx_if.tx_pop_i = 1'b1; tick(); tx_if.tx_pop_i = 1'b0; #1;
        check("t6_pop_ignored", tx_if.tx_thre_o, 1'b1);
        check("t6_temt", temt_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
